rand_vn_packer: RTL and testbench

- Downstream conditioning stage for the raw single-bit entropy sources (ADC-noise or clock-jitter sampler).
- Applies von Neumann debiasing to the raw bit stream, packs the extracted bits into ws-bit words, and offers each word on a valid/ready handshake to consumers such as the seed inputs of the LFSR and tempering generators.
- Counts words lost to back-pressure.

---
 rtl/rand_vn_packer.sv | 114 +++++++++++
 tb/tb_rand_vn_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rand_vn_packer.sv
// Von Neumann debiaser: packs extracted bits LSB-first into ws-bit words on a valid/ready output.
// Optional repetition-count health test enabled by defining RAND_HEALTH_EN.
module rand_vn_packer #(
  parameter int ws        = 16,
  parameter int OVF_W     = 8,
  parameter int RC_CUTOFF = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iBit,
  input  logic             iBitValid,
  input  logic             iReady,
  output logic [ws-1:0]    oOut,
  output logic             oValid,
  output logic [OVF_W-1:0] oOvf,
  output logic             oHealthFail
);

  localparam int CW = $clog2(ws);
  localparam logic [CW-1:0]    LAST    = CW'(ws - 1);
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  logic          m_have;
  logic          m_first;
  logic [ws-2:0] m_buf;
  logic [ws-2:0] buf_nxt;
  logic [CW-1:0] m_cnt;

  logic health_block;
  logic extract;
  logic complete;
  logic slot_free;

  // A differing pair yields its first bit: (1,0) -> 1, (0,1) -> 0.
  always_comb begin
    extract   = iBitValid & m_have & (m_first ^ iBit) & ~health_block;
    complete  = extract & (m_cnt == LAST);
    slot_free = ~oValid | iReady;
    buf_nxt   = m_buf;
    for (int i = 0; i < ws - 1; i++) begin
      if (m_cnt == CW'(i)) buf_nxt[i] = m_first;
    end
  end

  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      m_have  <= 1'b0;
      m_first <= 1'b0;
      m_buf   <= '0;
      m_cnt   <= '0;
      oOut    <= '0;
      oValid  <= 1'b0;
      oOvf    <= '0;
    end else begin
      if (iBitValid) begin
        m_have <= ~m_have;
        if (!m_have) m_first <= iBit;
      end
      if (extract) begin
        m_cnt <= complete ? '0 : m_cnt + 1'b1;
        if (!complete) m_buf <= buf_nxt;
      end
      // A completing word takes priority; it reuses the slot if the consumer accepts on this edge.
      if (complete) begin
        if (slot_free) begin
          oOut   <= {m_first, m_buf};
          oValid <= 1'b1;
        end else if (oOvf != OVF_MAX) begin
          oOvf <= oOvf + 1'b1;
        end
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

`ifdef RAND_HEALTH_EN
  localparam int RCW = $clog2(RC_CUTOFF + 1);
  localparam logic [RCW-1:0] RC_MAX = RCW'(RC_CUTOFF);

  logic [RCW-1:0] rc_cnt;
  logic [RCW-1:0] rc_nxt;
  logic           rc_prev;
  logic           fail_q;

  // A zero count marks "no previous bit yet", so the first bit after reset starts a run of 1.
  always_comb begin
    rc_nxt = RCW'(1);
    if (rc_cnt != '0 && iBit == rc_prev)
      rc_nxt = (rc_cnt == RC_MAX) ? rc_cnt : rc_cnt + 1'b1;
  end

  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rc_cnt  <= '0;
      rc_prev <= 1'b0;
      fail_q  <= 1'b0;
    end else if (iBitValid) begin
      rc_cnt  <= rc_nxt;
      rc_prev <= iBit;
      if (rc_nxt == RC_MAX) fail_q <= 1'b1;
    end
  end

  assign health_block = fail_q;
  assign oHealthFail  = fail_q;
`else
  logic unused_rc;
  assign unused_rc    = RC_CUTOFF[0];
  assign health_block = 1'b0;
  assign oHealthFail  = 1'b0;
`endif

endmodule

// File: tb/tb_rand_vn_packer.sv
// Directed bench for rand_vn_packer: inputs change on the rising edge, outputs sampled just after the falling edge.
module tb_rand_vn_packer;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iBit = 1'b0;
  logic        iBitValid = 1'b0;
  logic        iReady = 1'b0;
  logic [15:0] oOut;
  logic        oValid;
  logic [7:0]  oOvf;
  logic        oHealthFail;

  int errors = 0;
  int checks = 0;

  always #5 iCLK = ~iCLK;

  rand_vn_packer #(.ws(16), .OVF_W(8), .RC_CUTOFF(32)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iBit(iBit), .iBitValid(iBitValid), .iReady(iReady),
    .oOut(oOut), .oValid(oValid), .oOvf(oOvf), .oHealthFail(oHealthFail)
  );

  task automatic step(input logic b, input logic v, input logic r);
    @(posedge iCLK);
    iBit = b; iBitValid = v; iReady = r;
    @(negedge iCLK);
    #1;
  endtask

  task automatic pair(input logic a, input logic b, input logic r);
    step(a, 1'b1, r);
    step(b, 1'b1, r);
  endtask

  task automatic do_reset;
    @(posedge iCLK);
    iRST_N = 1'b0; iBit = 1'b0; iBitValid = 1'b0; iReady = 1'b0;
    @(posedge iCLK);
    @(posedge iCLK);
    iRST_N = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (oOut !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", oOut); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    checks++; if (oOvf !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", oOvf); end
    checks++; if (oHealthFail !== 1'b0) begin errors++; $display("FAIL reset_health: got %b expected 0", oHealthFail); end
  endtask

  task automatic test_alternating;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 0) pair(1'b1, 1'b0, 1'b1); else pair(1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL alt_early_valid: got %b expected 0", oValid); end
    step(1'b1, 1'b1, 1'b1);
    checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL alt_valid: got %b expected 1", oValid); end
    checks++; if (oOut !== 16'h5555) begin errors++; $display("FAIL alt_word: got %h expected 5555", oOut); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL alt_accept: got %b expected 0", oValid); end
    checks++; if (oOvf !== 8'd0) begin errors++; $display("FAIL alt_ovf: got %0d expected 0", oOvf); end
  endtask

  task automatic test_discard;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 0) pair(1'b1, 1'b0, 1'b0); else pair(1'b0, 1'b1, 1'b0);
      pair(1'b0, 1'b0, 1'b0);
      pair(1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL disc_early_valid: got %b expected 0", oValid); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (oOut !== 16'h5555 || oValid !== 1'b1) begin errors++; $display("FAIL disc_word: got %h/%b expected 5555/1", oOut, oValid); end
    pair(1'b0, 1'b0, 1'b0);
    pair(1'b1, 1'b1, 1'b0);
    checks++; if (oOut !== 16'h5555 || oValid !== 1'b1 || oOvf !== 8'd0) begin
      errors++; $display("FAIL disc_hold: got %h/%b/%0d expected 5555/1/0", oOut, oValid, oOvf); end
  endtask

  task automatic test_drop;
    do_reset();
    for (int k = 0; k < 16; k++) pair(1'b1, 1'b0, 1'b0);
    checks++; if (oOut !== 16'hFFFF || oValid !== 1'b1 || oOvf !== 8'd0) begin
      errors++; $display("FAIL drop_first: got %h/%b/%0d expected ffff/1/0", oOut, oValid, oOvf); end
    for (int k = 0; k < 16; k++) pair(1'b1, 1'b0, 1'b0);
    checks++; if (oOvf !== 8'd1) begin errors++; $display("FAIL drop_ovf: got %0d expected 1", oOvf); end
    checks++; if (oOut !== 16'hFFFF || oValid !== 1'b1) begin errors++; $display("FAIL drop_hold: got %h/%b expected ffff/1", oOut, oValid); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL drop_accept: got %b expected 0", oValid); end
    checks++; if (oOut !== 16'hFFFF || oOvf !== 8'd1) begin errors++; $display("FAIL drop_after: got %h/%0d expected ffff/1", oOut, oOvf); end
  endtask

  task automatic test_saturate;
    logic valid_lost;
    valid_lost = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) pair(1'b1, 1'b0, 1'b0);
    for (int w = 1; w < 300; w++) begin
      for (int k = 0; k < 16; k++) begin
        pair(1'b0, 1'b1, 1'b0);
        if (oValid !== 1'b1) valid_lost = 1'b1;
      end
      if (w == 100) begin
        checks++; if (oOvf !== 8'd100) begin errors++; $display("FAIL sat_mid: got %0d expected 100", oOvf); end
      end
    end
    checks++; if (oOvf !== 8'd255) begin errors++; $display("FAIL sat_ovf: got %0d expected 255", oOvf); end
    checks++; if (oOut !== 16'hFFFF) begin errors++; $display("FAIL sat_word: got %h expected ffff", oOut); end
    checks++; if (valid_lost !== 1'b0) begin errors++; $display("FAIL sat_valid: got dropped=%b expected 0", valid_lost); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 8; k++) pair(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    @(posedge iCLK);
    iRST_N = 1'b0; iBitValid = 1'b0; iReady = 1'b0;
    @(negedge iCLK);
    #1;
    checks++; if (oValid !== 1'b0 || oOut !== 16'h0000) begin errors++; $display("FAIL mid_in_reset: got %h/%b expected 0000/0", oOut, oValid); end
    @(posedge iCLK);
    iRST_N = 1'b1;
    for (int k = 0; k < 15; k++) pair(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b expected 0", oValid); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (oOut !== 16'h0000 || oValid !== 1'b1) begin errors++; $display("FAIL mid_word: got %h/%b expected 0000/1", oOut, oValid); end
    checks++; if (oOvf !== 8'd0) begin errors++; $display("FAIL mid_ovf: got %0d expected 0", oOvf); end
  endtask

  task automatic test_health;
    logic       exp_fail;
    logic       exp_valid;
`ifdef RAND_HEALTH_EN
    exp_fail = 1'b1; exp_valid = 1'b0;
`else
    exp_fail = 1'b0; exp_valid = 1'b1;
`endif
    do_reset();
    for (int k = 0; k < 31; k++) step(1'b1, 1'b1, 1'b0);
    checks++; if (oHealthFail !== 1'b0) begin errors++; $display("FAIL hlth_early: got %b expected 0", oHealthFail); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (oHealthFail !== exp_fail) begin errors++; $display("FAIL hlth_set: got %b expected %b", oHealthFail, exp_fail); end
    for (int k = 0; k < 16; k++) pair(1'b1, 1'b0, 1'b0);
    checks++; if (oValid !== exp_valid) begin errors++; $display("FAIL hlth_valid: got %b expected %b", oValid, exp_valid); end
    checks++; if (oHealthFail !== exp_fail || oOvf !== 8'd0) begin
      errors++; $display("FAIL hlth_sticky: got %b/%0d expected %b/0", oHealthFail, oOvf, exp_fail); end
    if (exp_valid) begin
      checks++; if (oOut !== 16'hFFFF) begin errors++; $display("FAIL hlth_word: got %h expected ffff", oOut); end
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_discard();
    test_drop();
    test_saturate();
    test_reset_mid();
    test_health();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
